// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron sequencer datapath.
package nn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ACC_WIDTH  = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_DRAIN,
    ST_OUTPUT
  } seq_state_t;

  // Counter wide enough to hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/neuron_out_quant.sv
// Combinational right-shift and unsigned saturation of an accumulator
// value down to the output data width.
module neuron_out_quant
  import nn_pkg::*;
#(
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OUT_SHIFT  = 0
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  output logic [DATA_WIDTH-1:0] q
);

  logic [ACC_WIDTH-1:0] shifted;

  assign shifted = acc >> OUT_SHIFT;

  generate
    if (ACC_WIDTH > DATA_WIDTH) begin : g_sat
      // Any set bit above the output width means the value is out of range.
      assign q = (|shifted[ACC_WIDTH-1:DATA_WIDTH]) ? {DATA_WIDTH{1'b1}}
                                                     : shifted[DATA_WIDTH-1:0];
    end else begin : g_pass
      assign q = DATA_WIDTH'(shifted);
    end
  endgenerate

endmodule

// File: rtl/neuron_sequencer.sv
// Drives an accumulator MAC through clear/accumulate/capture for each neuron
// of a layer and presents the quantised results on a valid/ready port.
module neuron_sequencer
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
  parameter int N_INPUTS   = 16,
  parameter int N_NEURONS  = 8,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_act,
  input  logic [DATA_WIDTH:0]   in_wgt,
  output logic                  mac_rst,
  output logic                  mac_en,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH:0]   mac_b,
  input  logic [ACC_WIDTH-1:0]  mac_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ACC_WIDTH-1:0]  out_raw
);

  localparam int BW = cnt_width(N_INPUTS);
  localparam int NW = cnt_width(N_NEURONS);
  localparam logic [BW-1:0] LAST_BEAT   = BW'(N_INPUTS - 1);
  localparam logic [NW-1:0] LAST_NEURON = NW'(N_NEURONS - 1);

  seq_state_t            state_q, state_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [NW-1:0]         neuron_cnt_q, neuron_cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ACC_WIDTH-1:0]  out_raw_q, out_raw_d;
  logic [DATA_WIDTH-1:0] quant_data;
  logic                  accum;

  neuron_out_quant #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_quant (
    .acc(mac_result),
    .q  (quant_data)
  );

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    neuron_cnt_d = neuron_cnt_q;
    out_data_d   = out_data_q;
    out_raw_d    = out_raw_q;
    case (state_q)
      ST_IDLE: begin
        beat_cnt_d   = '0;
        neuron_cnt_d = '0;
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        beat_cnt_d = '0;
        state_d    = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (in_valid) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = ST_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // The MAC output is registered, so the last beat is visible here.
        out_raw_d  = mac_result;
        out_data_d = quant_data;
        state_d    = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          if (neuron_cnt_q == LAST_NEURON) begin
            neuron_cnt_d = '0;
            state_d      = ST_IDLE;
          end else begin
            neuron_cnt_d = neuron_cnt_q + 1'b1;
            state_d      = ST_CLEAR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      neuron_cnt_q <= '0;
      out_data_q   <= '0;
      out_raw_q    <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      neuron_cnt_q <= neuron_cnt_d;
      out_data_q   <= out_data_d;
      out_raw_q    <= out_raw_d;
    end
  end

  assign accum     = (state_q == ST_ACCUM);
  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = accum;
  assign mac_en    = accum && in_valid;
  assign mac_a     = accum ? in_act : '0;
  assign mac_b     = accum ? in_wgt : '0;
  assign mac_rst   = rst || (state_q == ST_CLEAR);
  assign out_valid = (state_q == ST_OUTPUT);
  assign out_data  = out_data_q;
  assign out_raw   = out_raw_q;
  // Pulses during the final output handshake; a reset in that cycle aborts it.
  assign done      = out_valid && out_ready && (neuron_cnt_q == LAST_NEURON) && !rst;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Self-checking bench: two sequencer instances (3-neuron/unshifted and
// 1-neuron/shift-by-2) each driving a behavioural accumulator MAC.
module tb_neuron_sequencer;

  localparam int DW = 8;
  localparam int AW = 18;
  localparam int NI = 4;

  typedef logic [DW-1:0] act_arr_t [NI];
  typedef logic [DW:0]   wgt_arr_t [NI];

  typedef struct {
    logic [AW-1:0] raw;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [AW-1:0] raw;
    logic [DW-1:0] data;
    logic          dn;
    int            en_cyc;
    int            cyc;
    bit            saw_clr;
    bit            stable;
    bit            rdy_seen;
    bit            tmo;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0, s_start = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b1;
  logic [DW-1:0] in_act = '0;
  logic [DW:0]   in_wgt = '0;

  logic          busy, done, in_ready, mac_rst, mac_en, out_valid;
  logic [DW-1:0] mac_a, out_data;
  logic [DW:0]   mac_b;
  logic [AW-1:0] out_raw, acc0;

  logic          s_busy, s_done, s_in_ready, s_mac_rst, s_mac_en, s_out_valid;
  logic [DW-1:0] s_mac_a, s_out_data;
  logic [DW:0]   s_mac_b;
  logic [AW-1:0] s_out_raw, acc1;

  neuron_sequencer #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .N_INPUTS(NI), .N_NEURONS(3), .OUT_SHIFT(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
    .mac_rst(mac_rst), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_result(acc0), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_raw(out_raw)
  );

  neuron_sequencer #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .N_INPUTS(NI), .N_NEURONS(1), .OUT_SHIFT(2)
  ) dut_shift (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_act(in_act), .in_wgt(in_wgt),
    .mac_rst(s_mac_rst), .mac_en(s_mac_en), .mac_a(s_mac_a), .mac_b(s_mac_b),
    .mac_result(acc1), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_raw(s_out_raw)
  );

  // Behavioural accumulator MACs with a registered result.
  always_ff @(posedge clk) begin
    if (mac_rst) acc0 <= '0;
    else if (mac_en) acc0 <= acc0 + AW'(mac_a) * AW'(mac_b);
    if (s_mac_rst) acc1 <= '0;
    else if (s_mac_en) acc1 <= acc1 + AW'(s_mac_a) * AW'(s_mac_b);
  end

  logic sel = 1'b0;
  logic v_in_ready, v_mac_en, v_mac_rst, v_out_valid, v_done, v_busy;
  logic [DW-1:0] v_out_data;
  logic [AW-1:0] v_out_raw;
  assign v_in_ready  = sel ? s_in_ready  : in_ready;
  assign v_mac_en    = sel ? s_mac_en    : mac_en;
  assign v_mac_rst   = sel ? s_mac_rst   : mac_rst;
  assign v_out_valid = sel ? s_out_valid : out_valid;
  assign v_done      = sel ? s_done      : done;
  assign v_busy      = sel ? s_busy      : busy;
  assign v_out_data  = sel ? s_out_data  : out_data;
  assign v_out_raw   = sel ? s_out_raw   : out_raw;

  int n_cmp = 0;
  int n_err = 0;
  int done_count = 0;
  exp_t exp_q[$];

  always @(negedge clk) begin
    #2;
    if (v_done === 1'b1) done_count++;
  end

  function automatic void push_expect(input act_arr_t a, input wgt_arr_t w, input int shift);
    exp_t e;
    logic [AW-1:0] s;
    s = '0;
    for (int i = 0; i < NI; i++) s += AW'(a[i]) * AW'(w[i]);
    e.raw = s;
    s = s >> shift;
    e.data = (s > AW'(255)) ? 8'hFF : s[DW-1:0];
    exp_q.push_back(e);
  endfunction

  // Feeds one neuron's beats, waits for its output, optionally holds it
  // under backpressure, then performs the handshake and records observations.
  task automatic run_neuron(input act_arr_t a, input wgt_arr_t w, input logic [15:0] vpat,
                            input int hold, output obs_t o);
    int idx = 0;
    int k = 0;
    logic v;
    logic [AW-1:0] raw0;
    logic [DW-1:0] data0;
    o.raw = '0; o.data = '0; o.dn = 1'b0; o.en_cyc = 0; o.cyc = 0;
    o.saw_clr = 1'b0; o.stable = 1'b1; o.rdy_seen = 1'b0; o.tmo = 1'b0;
    out_ready = (hold == 0);
    while (idx < NI && o.cyc < 100) begin
      v = v_in_ready && ((k < 16) ? vpat[k[3:0]] : 1'b1);
      in_valid = v;
      in_act   = v ? a[idx] : '0;
      in_wgt   = v ? w[idx] : '0;
      #1;
      if (v_mac_en) o.en_cyc++;
      if (v_mac_rst && idx == 0) o.saw_clr = 1'b1;
      if (v_in_ready) begin
        k++;
        if (v) idx++;
      end
      @(negedge clk);
      o.cyc++;
    end
    in_valid = 1'b0; in_act = '0; in_wgt = '0;
    while (!v_out_valid && o.cyc < 200) begin
      @(negedge clk);
      o.cyc++;
    end
    o.tmo = (idx < NI) || !v_out_valid;
    if (!o.tmo) begin
      raw0 = v_out_raw;
      data0 = v_out_data;
      for (int h = 0; h < hold; h++) begin
        #1;
        if (!(v_out_valid && v_out_raw == raw0 && v_out_data == data0)) o.stable = 1'b0;
        if (v_in_ready) o.rdy_seen = 1'b1;
        @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      o.dn = v_done;
      o.raw = v_out_raw;
      o.data = v_out_data;
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, in_ready, mac_en, out_valid, mac_a, mac_b, out_data, out_raw} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0",
               {busy, done, in_ready, mac_en, out_valid, mac_a, mac_b, out_data, out_raw});
    end
    n_cmp++;
    if (mac_rst !== 1'b1 || s_mac_rst !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset_mac_rst: got %b/%b, expected 1/1", mac_rst, s_mac_rst);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mac_rst !== 1'b0 || busy !== 1'b0 || s_busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL post_reset_idle: got mac_rst=%b busy=%b s_busy=%b, expected 0 0 0",
               mac_rst, busy, s_busy);
    end
  endtask

  task automatic test_basic_latency();
    obs_t o;
    exp_t e;
    sel = 1'b1;
    done_count = 0;
    push_expect('{10, 20, 30, 40}, '{1, 1, 1, 1}, 2);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    run_neuron('{10, 20, 30, 40}, '{1, 1, 1, 1}, 16'hFFFF, 0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if (o.tmo || o.cyc + 1 != 7) begin
      n_err++;
      $display("[TB] FAIL latency: got out_valid at cycle %0d (timeout=%0b), expected 7", o.cyc + 1, o.tmo);
    end
    n_cmp++;
    if (o.raw !== e.raw || o.data !== e.data) begin
      n_err++;
      $display("[TB] FAIL basic_sum: got raw=%0d data=%0d, expected raw=%0d data=%0d", o.raw, o.data, e.raw, e.data);
    end
    n_cmp++;
    if (o.dn !== 1'b1 || !o.saw_clr) begin
      n_err++;
      $display("[TB] FAIL basic_done_clear: got done=%b clear=%b, expected 1 1", o.dn, o.saw_clr);
    end
    n_cmp++;
    if (s_busy !== 1'b0 || done_count != 1) begin
      n_err++;
      $display("[TB] FAIL basic_end: got busy=%b done_count=%0d, expected 0 1", s_busy, done_count);
    end
  endtask

  task automatic test_shift_saturation();
    obs_t o;
    exp_t e;
    sel = 1'b1;
    push_expect('{150, 150, 150, 150}, '{1, 1, 1, 1}, 2);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    run_neuron('{150, 150, 150, 150}, '{1, 1, 1, 1}, 16'hFFFF, 0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if (o.tmo || o.raw !== e.raw || o.data !== e.data) begin
      n_err++;
      $display("[TB] FAIL shift2: got raw=%0d data=%0d, expected raw=%0d data=%0d", o.raw, o.data, e.raw, e.data);
    end
    sel = 1'b0;
  endtask

  task automatic test_saturation();
    act_arr_t acts [3] = '{'{150, 150, 150, 150}, '{255, 255, 255, 255}, '{10, 20, 30, 40}};
    wgt_arr_t wgts [3] = '{'{1, 1, 1, 1}, '{256, 256, 256, 256}, '{1, 1, 1, 1}};
    obs_t o;
    exp_t e;
    for (int n = 0; n < 3; n++) push_expect(acts[n], wgts[n], 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      run_neuron(acts[n], wgts[n], 16'hFFFF, 0, o);
      e = exp_q.pop_front();
      n_cmp++;
      if (o.tmo || o.raw !== e.raw || o.data !== e.data) begin
        n_err++;
        $display("[TB] FAIL saturate_n%0d: got raw=%0d data=%0d, expected raw=%0d data=%0d",
                 n, o.raw, o.data, e.raw, e.data);
      end
    end
  endtask

  task automatic test_bubbles_backpressure();
    act_arr_t acts [3] = '{'{10, 20, 30, 40}, '{1, 2, 3, 4}, '{0, 0, 0, 7}};
    wgt_arr_t wgts [3] = '{'{1, 1, 1, 1}, '{3, 3, 3, 3}, '{5, 5, 5, 5}};
    obs_t o;
    exp_t e;
    for (int n = 0; n < 3; n++) push_expect(acts[n], wgts[n], 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_neuron(acts[0], wgts[0], 16'b1111_1111_1101_1001, 5, o);
    e = exp_q.pop_front();
    n_cmp++;
    if (o.en_cyc != 4) begin
      n_err++;
      $display("[TB] FAIL bubble_mac_en: got %0d enable cycles, expected 4", o.en_cyc);
    end
    n_cmp++;
    if (!o.stable || o.rdy_seen) begin
      n_err++;
      $display("[TB] FAIL backpressure_hold: got stable=%b in_ready_seen=%b, expected 1 0", o.stable, o.rdy_seen);
    end
    n_cmp++;
    if (o.tmo || o.raw !== e.raw || o.data !== e.data) begin
      n_err++;
      $display("[TB] FAIL bubble_sum: got raw=%0d data=%0d, expected raw=%0d data=%0d", o.raw, o.data, e.raw, e.data);
    end
    for (int n = 1; n < 3; n++) begin
      run_neuron(acts[n], wgts[n], 16'hFFFF, 0, o);
      e = exp_q.pop_front();
      n_cmp++;
      if (o.tmo || o.raw !== e.raw || o.data !== e.data) begin
        n_err++;
        $display("[TB] FAIL bubble_tail_n%0d: got raw=%0d data=%0d, expected raw=%0d data=%0d",
                 n, o.raw, o.data, e.raw, e.data);
      end
    end
  endtask

  task automatic test_multi_neuron();
    act_arr_t acts [3] = '{'{1, 1, 2, 2}, '{2, 3, 4, 5}, '{3, 3, 3, 3}};
    wgt_arr_t wgts [3] = '{'{1, 1, 1, 1}, '{1, 1, 1, 1}, '{2, 2, 3, 3}};
    obs_t o;
    exp_t e;
    done_count = 0;
    for (int n = 0; n < 3; n++) push_expect(acts[n], wgts[n], 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      run_neuron(acts[n], wgts[n], 16'hFFFF, 0, o);
      e = exp_q.pop_front();
      n_cmp++;
      if (o.tmo || o.raw !== e.raw || o.data !== e.data) begin
        n_err++;
        $display("[TB] FAIL multi_n%0d: got raw=%0d data=%0d, expected raw=%0d data=%0d",
                 n, o.raw, o.data, e.raw, e.data);
      end
      n_cmp++;
      if (!o.saw_clr || o.dn !== (n == 2) || out_valid !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL multi_ctrl_n%0d: got clear=%b done=%b valid_after=%b, expected 1 %0d 0",
                 n, o.saw_clr, o.dn, out_valid, (n == 2));
      end
    end
    n_cmp++;
    if (done_count != 1 || busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL multi_end: got done_count=%0d busy=%b, expected 1 0", done_count, busy);
    end
  endtask

  task automatic test_reset_mid_accum();
    act_arr_t acts [3] = '{'{5, 5, 5, 5}, '{1, 1, 1, 1}, '{2, 2, 2, 2}};
    wgt_arr_t wgts [3] = '{'{1, 1, 1, 1}, '{1, 1, 1, 1}, '{2, 2, 2, 2}};
    obs_t o;
    exp_t e;
    int accepted = 0;
    int cyc = 0;
    done_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (accepted < 2 && cyc < 20) begin
      in_valid = in_ready;
      in_act = 8'd77;
      in_wgt = 9'd3;
      if (in_ready) accepted++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (mac_rst !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL mid_reset_assert: got mac_rst=%b busy=%b, expected 1 1", mac_rst, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, in_ready, mac_en, out_valid, mac_rst, mac_a, mac_b, out_data, out_raw} !== '0
        || done_count != 0) begin
      n_err++;
      $display("[TB] FAIL mid_reset_idle: got %h done_count=%0d, expected 0 0",
               {busy, done, in_ready, mac_en, out_valid, mac_rst, mac_a, mac_b, out_data, out_raw}, done_count);
    end
    @(negedge clk);
    for (int n = 0; n < 3; n++) push_expect(acts[n], wgts[n], 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      run_neuron(acts[n], wgts[n], 16'hFFFF, 0, o);
      e = exp_q.pop_front();
      n_cmp++;
      if (o.tmo || o.raw !== e.raw || o.data !== e.data) begin
        n_err++;
        $display("[TB] FAIL after_reset_n%0d: got raw=%0d data=%0d, expected raw=%0d data=%0d",
                 n, o.raw, o.data, e.raw, e.data);
      end
    end
  endtask

  task automatic test_start_while_busy();
    act_arr_t acts [3] = '{'{9, 8, 7, 6}, '{4, 4, 4, 4}, '{1, 0, 1, 0}};
    wgt_arr_t wgts [3] = '{'{1, 1, 1, 1}, '{10, 10, 10, 10}, '{100, 100, 100, 100}};
    obs_t o;
    exp_t e;
    bit busy_seen = 1'b0;
    done_count = 0;
    for (int n = 0; n < 3; n++) push_expect(acts[n], wgts[n], 0);
    start = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      run_neuron(acts[n], wgts[n], 16'hFFFF, 0, o);
      e = exp_q.pop_front();
      n_cmp++;
      if (o.tmo || o.raw !== e.raw || o.data !== e.data) begin
        n_err++;
        $display("[TB] FAIL busy_start_n%0d: got raw=%0d data=%0d, expected raw=%0d data=%0d",
                 n, o.raw, o.data, e.raw, e.data);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (busy !== 1'b0 || out_valid !== 1'b0) busy_seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (busy_seen || done_count != 1) begin
      n_err++;
      $display("[TB] FAIL start_with_done: got restarted=%b done_count=%0d, expected 0 1", busy_seen, done_count);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_latency();
    test_shift_saturation();
    test_saturation();
    test_bubbles_backpressure();
    test_multi_neuron();
    test_reset_mid_accum();
    test_start_while_busy();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
